// File: rtl/adder_share_ctrl.sv
// Byte-serial adder shared between two round-robin requesters, built around one 8-bit hybrid adder.
// Optional subtract mode is enabled by defining ADDER_SHARE_CTRL_SUB_EN (adds ports sub0/sub1).

module hybrid_binary_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  logic       grp_g;

  // Ripple inside each nibble; the upper nibble's carry-in comes from a group lookahead.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 3; i++) c[i+1] = g[i] | (p[i] & c[i]);
    grp_g = 1'b0;
    for (int i = 0; i < 4; i++) grp_g = g[i] | (p[i] & grp_g);
    c[4] = grp_g | ((&p[3:0]) & cin);
    for (int i = 4; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    sum  = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module adder_share_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic [8*NBYTES-1:0] a0,
  input  logic [8*NBYTES-1:0] b0,
  input  logic [8*NBYTES-1:0] a1,
  input  logic [8*NBYTES-1:0] b1,
  input  logic                cin0,
  input  logic                cin1,
`ifdef ADDER_SHARE_CTRL_SUB_EN
  input  logic                sub0,
  input  logic                sub1,
`endif
  output logic                ack0,
  output logic                ack1,
  output logic                done0,
  output logic                done1,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state, state_nxt;
  logic          capture, step, finish;
  logic          pick1;
  logic          ptr, owner, carry_q;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q, shadow;
  logic [W-1:0]  op_b0, op_b1;
  logic          op_c0, op_c1;
  logic [7:0]    add_sum;
  logic          add_cout;
  logic [KW+2:0] byte_lsb;

  // Subtraction is folded into the captured operands: a + ~b + 1.
`ifdef ADDER_SHARE_CTRL_SUB_EN
  assign op_b0 = sub0 ? ~b0 : b0;
  assign op_b1 = sub1 ? ~b1 : b1;
  assign op_c0 = sub0 | cin0;
  assign op_c1 = sub1 | cin1;
`else
  assign op_b0 = b0;
  assign op_b1 = b1;
  assign op_c0 = cin0;
  assign op_c1 = cin1;
`endif

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign pick1    = req1 & (~req0 | ptr);
  assign busy     = (state != IDLE);
  assign byte_lsb = {k, 3'b000};

  hybrid_binary_adder u_adder (
    .a    (a_q[byte_lsb +: 8]),
    .b    (b_q[byte_lsb +: 8]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          capture   = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (k == KW'(NBYTES - 1)) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      owner   <= 1'b0;
      k       <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      ack0  <= capture & ~pick1;
      ack1  <= capture & pick1;
      done0 <= finish & ~owner;
      done1 <= finish & owner;
      if (capture) begin
        owner   <= pick1;
        ptr     <= ~ptr;
        k       <= '0;
        carry_q <= pick1 ? op_c1 : op_c0;
      end
      if (step) begin
        carry_q <= add_cout;
        k       <= k + 1'b1;
      end
      if (finish) begin
        result <= shadow;
        cout   <= carry_q;
      end
    end
  end

  // NOTE: operand and shadow registers are deliberately not reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_q <= pick1 ? a1 : a0;
      b_q <= pick1 ? op_b1 : op_b0;
    end
    if (step) shadow[byte_lsb +: 8] <= add_sum;
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: driver issues requests, monitor predicts grants and sums.
module tb_adder_share_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, done0, done1, cout, busy;
  logic [W-1:0] result;
`ifdef ADDER_SHARE_CTRL_SUB_EN
  logic         sub0 = 1'b0, sub1 = 1'b0;
`endif

  adder_share_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
`ifdef ADDER_SHARE_CTRL_SUB_EN
    .sub0(sub0), .sub1(sub1),
`endif
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           owner;
    logic [W-1:0] res;
    bit           co;
    int           ack_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide arithmetic on the operands the requester held when granted.
  function automatic exp_t model(input bit owner, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit cin, input bit sub, input int c);
    logic [W:0]   full;
    logic [W-1:0] nb;
    exp_t e;
    nb = ~b;
    if (sub) full = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    e.owner   = owner;
    e.res     = full[W-1:0];
    e.co      = full[W];
    e.ack_cyc = c;
    return e;
  endfunction

  // Monitor: all sampling on the falling edge.
  logic         p_req0 = 1'b0, p_req1 = 1'b0, p_cin0 = 1'b0, p_cin1 = 1'b0;
  logic [W-1:0] p_a0 = '0, p_b0 = '0, p_a1 = '0, p_b1 = '0;
  bit           p_sub0 = 1'b0, p_sub1 = 1'b0;
  bit           ptr_m = 1'b0, rst_seen = 1'b0;
  int           wait0 = 0, wait1 = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   exp_win;
    cyc++;
    check("ack_done_exclusive", 64'({ack0 & ack1, done0 & done1}), 64'(0));
    if (ack0 || ack1) begin
      exp_win = (p_req0 && p_req1) ? ptr_m : p_req1;
      check("grant_owner", 64'(ack1), 64'(exp_win));
      check("grant_had_req", 64'(ack1 ? p_req1 : p_req0), 64'(1));
      if (ack1) sb.push_back(model(1'b1, p_a1, p_b1, p_cin1, p_sub1, cyc));
      else      sb.push_back(model(1'b0, p_a0, p_b0, p_cin0, p_sub0, cyc));
      ptr_m = ~ptr_m;
    end
    if (done0 || done1) begin
      check("done_has_pending_op", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_owner", 64'(done1), 64'(e.owner));
        check("result", 64'(result), 64'(e.res));
        check("cout", 64'(cout), 64'(e.co));
        check("latency", 64'(cyc - e.ack_cyc), 64'(NBYTES + 1));
      end
    end
    check("busy", 64'(busy), 64'(sb.size() != 0));
    if (rst_seen) check("reset_result_cout", 64'({cout, result}), 64'(0));
    rst_seen = 1'b0;
    if (sb.size() != 0 && (cyc - sb[0].ack_cyc) > NBYTES + 3) begin
      check("done_timeout", 64'(cyc - sb[0].ack_cyc), 64'(NBYTES + 1));
      void'(sb.pop_front());
    end
    wait0 = (req0 && !ack0) ? wait0 + 1 : 0;
    wait1 = (req1 && !ack1) ? wait1 + 1 : 0;
    if (wait0 > 60) begin check("req0_starved", 64'(wait0), 64'(0)); wait0 = 0; end
    if (wait1 > 60) begin check("req1_starved", 64'(wait1), 64'(0)); wait1 = 0; end
    if (!rst_n) begin
      sb.delete();
      ptr_m    = 1'b0;
      rst_seen = 1'b1;
    end
    p_req0 = req0; p_req1 = req1; p_cin0 = cin0; p_cin1 = cin1;
    p_a0 = a0; p_b0 = b0; p_a1 = a1; p_b1 = b1;
`ifdef ADDER_SHARE_CTRL_SUB_EN
    p_sub0 = sub0; p_sub1 = sub1;
`endif
  end

  // Driver: inputs change 1 time unit after the rising edge.
  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic new_ops(input int who);
    if (who == 0) begin
      a0 = rnd_word(); b0 = rnd_word(); cin0 = 1'($urandom_range(0, 1));
`ifdef ADDER_SHARE_CTRL_SUB_EN
      sub0 = 1'($urandom_range(0, 1));
`endif
    end else begin
      a1 = rnd_word(); b1 = rnd_word(); cin1 = 1'($urandom_range(0, 1));
`ifdef ADDER_SHARE_CTRL_SUB_EN
      sub1 = 1'($urandom_range(0, 1));
`endif
    end
  endtask

  // After an ack the requester either drops its request or immediately re-requests; operands
  // are scrambled either way so a late change would corrupt the operation in flight.
  task automatic tick(input bit keep0, input bit keep1);
    @(posedge clk);
    #1;
    if (ack0) begin req0 = keep0; new_ops(0); end
    if (ack1) begin req1 = keep1; new_ops(1); end
  endtask

  task automatic wait_ack(input int who);
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0);
      if ((who == 0 && ack0) || (who == 1 && ack1)) return;
    end
    check("ack_wait", 64'(who == 0 ? ack0 : ack1), 64'(1));
  endtask

  int  n_acks;
  bit  last_owner;

  initial begin
    repeat (3) tick(1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // Carry out of byte 0 into byte 1.
    a0 = 32'h0000_00FF; b0 = 32'h0000_0001; cin0 = 1'b0; req0 = 1'b1;
    wait_ack(0);
    repeat (8) tick(1'b0, 1'b0);

    // Carry ripples through every byte.
    a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0000; cin1 = 1'b1; req1 = 1'b1;
    wait_ack(1);
    repeat (8) tick(1'b0, 1'b0);

    // Both held continuously: grants must alternate.
    new_ops(0); new_ops(1); req0 = 1'b1; req1 = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ack0 || ack1) begin
        if (n_acks > 0) check("alternate", 64'(ack1), 64'(!last_owner));
        last_owner = ack1;
        n_acks++;
      end
      if (ack0) new_ops(0);
      if (ack1) new_ops(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) tick(1'b0, 1'b0);

    // Reset mid-operation: no done for the aborted op, then a clean retry.
    new_ops(0); req0 = 1'b1;
    wait_ack(0);
    tick(1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    new_ops(0); req0 = 1'b1;
    wait_ack(0);
    repeat (8) tick(1'b0, 1'b0);

`ifdef ADDER_SHARE_CTRL_SUB_EN
    a0 = 32'd5; b0 = 32'd6; cin0 = 1'b0; sub0 = 1'b1; req0 = 1'b1;
    wait_ack(0);
    repeat (8) tick(1'b0, 1'b0);
    a0 = 32'd200; b0 = 32'd152; cin0 = 1'b1; sub0 = 1'b1; req0 = 1'b1;
    wait_ack(0);
    repeat (8) tick(1'b0, 1'b0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!req0 && $urandom_range(0, 3) == 0) begin new_ops(0); req0 = 1'b1; end
      if (!req1 && $urandom_range(0, 3) == 0) begin new_ops(1); req1 = 1'b1; end
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (20) tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
